// File: rtl/multdiv_issue_ctrl_pkg.sv
// Shared types and defaults for the mult/div issue controller.
// Optional watchdog build: define MULTDIV_TIMEOUT_EN.
package multdiv_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_e;

    localparam logic [4:0]  STATUS_REG_DEF = 5'd30;
    localparam logic [31:0] MULT_CODE_DEF  = 32'd4;
    localparam logic [31:0] DIV_CODE_DEF   = 32'd5;

    // Operand/destination latch layout, 69 bits wide.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } opnd_t;

    localparam int OPND_W = $bits(opnd_t);

    function automatic logic [31:0] exc_code(input op_e op, input logic [31:0] mult_code,
                                             input logic [31:0] div_code);
        return (op == OP_MULT) ? mult_code : div_code;
    endfunction

endpackage

// File: rtl/multdiv_issue_ctrl_if.sv
// X-stage, mult/div unit and writeback signals of the issue controller.
// master = controller side, slave = pipeline/unit side.
interface multdiv_issue_ctrl_if;
    logic        ex_is_mult;
    logic        ex_is_div;
    logic [31:0] ex_operandA;
    logic [31:0] ex_operandB;
    logic [4:0]  ex_rd;

    logic        unit_clear;
    logic        mult_enable;
    logic        div_enable;
    logic [31:0] unit_operandA;
    logic [31:0] unit_operandB;

    logic [31:0] mult_result;
    logic        mult_exception;
    logic        mult_resultrdy;
    logic [31:0] div_result;
    logic        div_exception;
    logic        div_resultrdy;

    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exception;

    modport master (
        input  ex_is_mult, ex_is_div, ex_operandA, ex_operandB, ex_rd,
        input  mult_result, mult_exception, mult_resultrdy,
        input  div_result, div_exception, div_resultrdy,
        output unit_clear, mult_enable, div_enable, unit_operandA, unit_operandB,
        output stall, wb_valid, wb_rd, wb_data, wb_exception
    );

    modport slave (
        output ex_is_mult, ex_is_div, ex_operandA, ex_operandB, ex_rd,
        output mult_result, mult_exception, mult_resultrdy,
        output div_result, div_exception, div_resultrdy,
        input  unit_clear, mult_enable, div_enable, unit_operandA, unit_operandB,
        input  stall, wb_valid, wb_rd, wb_data, wb_exception
    );
endinterface

// File: rtl/multdiv_watchdog.sv
// BUSY-cycle counter for the issue controller; only built with MULTDIV_TIMEOUT_EN.
module multdiv_watchdog #(
    parameter int LIMIT = 40
) (
    input  logic clock,
    input  logic clear,
    input  logic run,
    output logic expired
);
    localparam int          W    = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q;

    // First BUSY cycle sees count 0, so expiry lands on the LIMIT-th BUSY cycle.
    always_ff @(posedge clock) begin
        if (clear || !run)  cnt_q <= '0;
        else if (!expired)  cnt_q <= cnt_q + 1'b1;
    end

    assign expired = run && (cnt_q == LAST);
endmodule

// File: rtl/register.sv
// Generic loadable register with synchronous active-high clear.
module register #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clock) begin
        if (clear)   q <= '0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issue/stall controller in front of the mult and div units: launch, wait, one writeback beat.
// Define MULTDIV_TIMEOUT_EN to add a BUSY watchdog that forces an exception writeback.
module multdiv_issue_ctrl
    import multdiv_issue_ctrl_pkg::*;
#(
    parameter logic [4:0]  STATUS_REG = STATUS_REG_DEF,
    parameter logic [31:0] MULT_CODE  = MULT_CODE_DEF,
    parameter logic [31:0] DIV_CODE   = DIV_CODE_DEF
`ifdef MULTDIV_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYC = 40
`endif
) (
    input  logic                   clock,
    input  logic                   clear,
    multdiv_issue_ctrl_if.master   bus
);

    state_e      state_q;
    op_e         op_q;
    logic        unit_clear_q, mult_en_q, div_en_q;
    logic        wb_valid_q, wb_exc_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_data_q;

    opnd_t       opnd_d, opnd_q;
    logic        issue, latch_en, timeout, finish;
    logic        sel_rdy, sel_exc;
    logic [31:0] sel_result;
    logic        wb_exc_d;
    logic [4:0]  wb_rd_d;
    logic [31:0] wb_data_d;

    assign issue    = bus.ex_is_mult | bus.ex_is_div;
    assign latch_en = (state_q == ST_IDLE) && issue;
    assign opnd_d   = {bus.ex_operandA, bus.ex_operandB, bus.ex_rd};

    // Units see registered operands: mult_exception is combinational on them.
    register #(.WIDTH(OPND_W)) u_opnd_reg (
        .clock (clock),
        .clear (clear),
        .en    (latch_en),
        .d     (opnd_d),
        .q     (opnd_q)
    );

`ifdef MULTDIV_TIMEOUT_EN
    multdiv_watchdog #(.LIMIT(TIMEOUT_CYC)) u_watchdog (
        .clock   (clock),
        .clear   (clear),
        .run     (state_q == ST_BUSY),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        sel_rdy    = (op_q == OP_MULT) ? bus.mult_resultrdy : bus.div_resultrdy;
        sel_exc    = (op_q == OP_MULT) ? bus.mult_exception : bus.div_exception;
        sel_result = (op_q == OP_MULT) ? bus.mult_result    : bus.div_result;
        finish     = (state_q == ST_BUSY) && (sel_rdy || timeout);
        // A watchdog expiry without rdy is reported as the op's exception.
        wb_exc_d   = sel_rdy ? sel_exc : 1'b1;
        wb_rd_d    = wb_exc_d ? STATUS_REG : opnd_q.rd;
        wb_data_d  = wb_exc_d ? exc_code(op_q, MULT_CODE, DIV_CODE) : sel_result;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_MULT;
            unit_clear_q <= 1'b0;
            mult_en_q    <= 1'b0;
            div_en_q     <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_exc_q     <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
        end else begin
            unit_clear_q <= 1'b0;
            mult_en_q    <= 1'b0;
            div_en_q     <= 1'b0;
            wb_valid_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        state_q      <= ST_LAUNCH;
                        op_q         <= bus.ex_is_mult ? OP_MULT : OP_DIV;
                        unit_clear_q <= 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    state_q   <= ST_BUSY;
                    mult_en_q <= (op_q == OP_MULT);
                    div_en_q  <= (op_q == OP_DIV);
                end
                ST_BUSY: begin
                    if (finish) begin
                        state_q    <= ST_DONE;
                        wb_valid_q <= 1'b1;
                        wb_exc_q   <= wb_exc_d;
                        wb_rd_q    <= wb_rd_d;
                        wb_data_q  <= wb_data_d;
                    end else begin
                        mult_en_q <= (op_q == OP_MULT);
                        div_en_q  <= (op_q == OP_DIV);
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Stall covers the issue cycle itself, so it cannot wait for a register.
    assign bus.stall = !clear && (((state_q == ST_IDLE) && issue) ||
                                  (state_q == ST_LAUNCH) || (state_q == ST_BUSY));

    assign bus.unit_clear    = unit_clear_q;
    assign bus.mult_enable   = mult_en_q;
    assign bus.div_enable    = div_en_q;
    assign bus.unit_operandA = opnd_q.a;
    assign bus.unit_operandB = opnd_q.b;
    assign bus.wb_valid      = wb_valid_q;
    assign bus.wb_rd         = wb_rd_q;
    assign bus.wb_data       = wb_data_q;
    assign bus.wb_exception  = wb_exc_q;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Directed bench for multdiv_issue_ctrl with small behavioural mult/div unit models.
module tb_multdiv_issue_ctrl;

    logic clock = 1'b0;
    logic clear = 1'b1;
    always #5 clock = ~clock;

    multdiv_issue_ctrl_if bus();

    multdiv_issue_ctrl dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.master)
    );

    int checks = 0;
    int errors = 0;
    int wb_pulses = 0;

    // Unit models: mult rdy on 17th enabled cycle, div on 8th.
    logic [5:0]         mcnt, dcnt;
    logic               kill_mult = 1'b0;
    logic               spur_div  = 1'b0;
    logic signed [63:0] sa, sb, prod;

    assign sa   = $signed(bus.unit_operandA);
    assign sb   = $signed(bus.unit_operandB);
    assign prod = sa * sb;

    always_ff @(posedge clock) begin
        if (clear || bus.unit_clear) mcnt <= '0;
        else if (bus.mult_enable)    mcnt <= mcnt + 6'd1;
        if (clear || bus.unit_clear) dcnt <= '0;
        else if (bus.div_enable)     dcnt <= dcnt + 6'd1;
    end

    assign bus.mult_result    = prod[31:0];
    assign bus.mult_exception = !((&prod[63:31]) || !(|prod[63:31]));
    assign bus.mult_resultrdy = bus.mult_enable && (mcnt == 6'd16) && !kill_mult;
    assign bus.div_result     = (bus.unit_operandB == 32'd0) ? 32'd0 : bus.unit_operandA / bus.unit_operandB;
    assign bus.div_exception  = (bus.unit_operandB == 32'd0) || spur_div;
    assign bus.div_resultrdy  = (bus.div_enable && (dcnt == 6'd7)) || spur_div;

    always @(negedge clock) if (bus.wb_valid === 1'b1) wb_pulses++;

    // Drives one op, holding X while stalled; returns at +1 after the DONE cycle.
    task automatic run_op(input logic is_mult, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int lat, output int stalls,
                          output logic [4:0] g_rd, output logic [31:0] g_data,
                          output logic g_exc, output logic done_stall, output int opnd_bad);
        int c;
        bus.ex_is_mult = is_mult;  bus.ex_is_div = !is_mult;
        bus.ex_operandA = a;  bus.ex_operandB = b;  bus.ex_rd = rd;
        lat = -1; stalls = 0; opnd_bad = 0; c = 0;
        g_rd = '0; g_data = '0; g_exc = 1'b0; done_stall = 1'b1;
        while (lat < 0 && c < 100) begin
            #1;
            if (bus.stall) stalls++;
            if (c > 0 && (bus.unit_operandA !== a || bus.unit_operandB !== b)) opnd_bad++;
            if (bus.wb_valid === 1'b1) begin
                lat = c; g_rd = bus.wb_rd; g_data = bus.wb_data;
                g_exc = bus.wb_exception; done_stall = bus.stall;
            end
            @(posedge clock); #1;
            c++;
        end
    endtask

    task automatic idle_inputs();
        bus.ex_is_mult = 1'b0; bus.ex_is_div = 1'b0;
        bus.ex_operandA = '0; bus.ex_operandB = '0; bus.ex_rd = '0;
    endtask

    task automatic test_reset();
        bus.ex_is_mult = 1'b1; bus.ex_is_div = 1'b0;
        bus.ex_operandA = 32'h1234; bus.ex_operandB = 32'h55; bus.ex_rd = 5'd9;
        clear = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", bus.wb_valid); end
        checks++; if (bus.unit_operandA !== 32'd0) begin errors++; $display("FAIL reset_opA: got %h want 0", bus.unit_operandA); end
        checks++; if ({bus.unit_clear, bus.mult_enable, bus.div_enable} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b want 000", {bus.unit_clear, bus.mult_enable, bus.div_enable}); end
        checks++; if ({bus.wb_rd, bus.wb_data, bus.wb_exception} !== 38'd0) begin errors++; $display("FAIL reset_wb: got %h want 0", {bus.wb_rd, bus.wb_data, bus.wb_exception}); end
        idle_inputs();
        @(posedge clock); #1;
        clear = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_mult_basic();
        int lat, st, bad; logic [4:0] r; logic [31:0] d; logic e, ds;
        run_op(1'b1, 32'd7, 32'd6, 5'd5, lat, st, r, d, e, ds, bad);
        idle_inputs();
        checks++; if (st !== 19) begin errors++; $display("FAIL mult_stall_cycles: got %0d want 19", st); end
        checks++; if (lat !== 19) begin errors++; $display("FAIL mult_latency: got %0d want 19", lat); end
        checks++; if (r !== 5'd5) begin errors++; $display("FAIL mult_wb_rd: got %0d want 5", r); end
        checks++; if (d !== 32'd42) begin errors++; $display("FAIL mult_wb_data: got %0d want 42", d); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL mult_wb_exc: got %b want 0", e); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL mult_opnd_hold: got %0d bad cycles want 0", bad); end
        @(posedge clock); #1;
    endtask

    task automatic test_mult_overflow();
        int lat, st, bad; logic [4:0] r; logic [31:0] d; logic e, ds;
        run_op(1'b1, 32'h4000_0000, 32'd4, 5'd3, lat, st, r, d, e, ds, bad);
        idle_inputs();
        checks++; if (r !== 5'd30) begin errors++; $display("FAIL ovf_wb_rd: got %0d want 30", r); end
        checks++; if (d !== 32'd4) begin errors++; $display("FAIL ovf_wb_data: got %0d want 4", d); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL ovf_wb_exc: got %b want 1", e); end
        checks++; if (lat !== 19) begin errors++; $display("FAIL ovf_latency: got %0d want 19", lat); end
        @(posedge clock); #1;
    endtask

    task automatic test_div();
        int lat, st, bad; logic [4:0] r; logic [31:0] d; logic e, ds;
        run_op(1'b0, 32'd7, 32'd0, 5'd8, lat, st, r, d, e, ds, bad);
        idle_inputs();
        checks++; if (r !== 5'd30) begin errors++; $display("FAIL div0_wb_rd: got %0d want 30", r); end
        checks++; if (d !== 32'd5) begin errors++; $display("FAIL div0_wb_data: got %0d want 5", d); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL div0_wb_exc: got %b want 1", e); end
        checks++; if (lat !== 10) begin errors++; $display("FAIL div0_latency: got %0d want 10", lat); end
        @(posedge clock); #1;
        run_op(1'b0, 32'd100, 32'd7, 5'd9, lat, st, r, d, e, ds, bad);
        idle_inputs();
        checks++; if ({r, d, e} !== {5'd9, 32'd14, 1'b0}) begin errors++; $display("FAIL div_wb: got rd=%0d data=%0d exc=%b want rd=9 data=14 exc=0", r, d, e); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL div_opnd_hold: got %0d bad cycles want 0", bad); end
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back();
        int lat1, st1, lat2, st2, bad, p0; logic [4:0] r1, r2; logic [31:0] d1, d2; logic e1, e2, ds1, ds2;
        p0 = wb_pulses;
        run_op(1'b1, 32'hFFFF_FFFD, 32'd5, 5'd10, lat1, st1, r1, d1, e1, ds1, bad);
        run_op(1'b1, 32'd2, 32'd2, 5'd11, lat2, st2, r2, d2, e2, ds2, bad);
        idle_inputs();
        repeat (3) @(posedge clock); #1;
        checks++; if (d1 !== 32'hFFFF_FFF1) begin errors++; $display("FAIL b2b_first_data: got %h want fffffff1", d1); end
        checks++; if (d2 !== 32'd4) begin errors++; $display("FAIL b2b_second_data: got %h want 4", d2); end
        checks++; if (ds1 !== 1'b0) begin errors++; $display("FAIL b2b_done_stall: got %b want 0", ds1); end
        checks++; if (st2 !== 19 || lat2 !== 19) begin errors++; $display("FAIL b2b_second_timing: got stall=%0d lat=%0d want 19/19", st2, lat2); end
        checks++; if (wb_pulses - p0 !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", wb_pulses - p0); end
    endtask

    task automatic test_clear_busy();
        int lat, st, bad, p0; logic [4:0] r; logic [31:0] d; logic e, ds;
        p0 = wb_pulses;
        bus.ex_is_mult = 1'b1; bus.ex_is_div = 1'b0;
        bus.ex_operandA = 32'd9; bus.ex_operandB = 32'd9; bus.ex_rd = 5'd4;
        repeat (7) begin @(posedge clock); #1; end
        #1;
        checks++; if (bus.mult_enable !== 1'b1) begin errors++; $display("FAIL clr_in_busy: got enable=%b want 1", bus.mult_enable); end
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
        idle_inputs();
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL clr_stall: got %b want 0", bus.stall); end
        checks++; if ({bus.wb_valid, bus.mult_enable, bus.unit_clear} !== 3'b000) begin errors++; $display("FAIL clr_outputs: got %b want 000", {bus.wb_valid, bus.mult_enable, bus.unit_clear}); end
        repeat (25) begin @(posedge clock); #1; end
        checks++; if (wb_pulses !== p0) begin errors++; $display("FAIL clr_no_wb: got %0d pulses want 0", wb_pulses - p0); end
        run_op(1'b1, 32'd3, 32'd3, 5'd6, lat, st, r, d, e, ds, bad);
        idle_inputs();
        checks++; if ({r, d, e} !== {5'd6, 32'd9, 1'b0} || lat !== 19) begin errors++; $display("FAIL clr_reissue: got rd=%0d data=%0d exc=%b lat=%0d want 6/9/0/19", r, d, e, lat); end
        @(posedge clock); #1;
    endtask

    task automatic test_ignore_other_rdy();
        int lat, st, bad; logic [4:0] r; logic [31:0] d; logic e, ds;
        spur_div = 1'b1;
        run_op(1'b1, 32'd5, 32'd5, 5'd7, lat, st, r, d, e, ds, bad);
        idle_inputs();
        spur_div = 1'b0;
        checks++; if (lat !== 19) begin errors++; $display("FAIL other_rdy_latency: got %0d want 19", lat); end
        checks++; if ({r, d, e} !== {5'd7, 32'd25, 1'b0}) begin errors++; $display("FAIL other_rdy_wb: got rd=%0d data=%0d exc=%b want 7/25/0", r, d, e); end
        @(posedge clock); #1;
    endtask

`ifdef MULTDIV_TIMEOUT_EN
    task automatic test_timeout();
        int lat, st, bad; logic [4:0] r; logic [31:0] d; logic e, ds;
        kill_mult = 1'b1;
        run_op(1'b1, 32'd7, 32'd6, 5'd5, lat, st, r, d, e, ds, bad);
        idle_inputs();
        kill_mult = 1'b0;
        checks++; if (lat !== 42) begin errors++; $display("FAIL timeout_latency: got %0d want 42", lat); end
        checks++; if ({r, d, e} !== {5'd30, 32'd4, 1'b1}) begin errors++; $display("FAIL timeout_wb: got rd=%0d data=%0d exc=%b want 30/4/1", r, d, e); end
        @(posedge clock); #1;
    endtask
`endif

    initial begin
        idle_inputs();
        test_reset();
        test_mult_basic();
        test_mult_overflow();
        test_div();
        test_back_to_back();
        test_clear_busy();
        test_ignore_other_rdy();
`ifdef MULTDIV_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
